burst_line_master: RTL and testbench

//  Initiator side of the BurstRAM command/burst interface. Takes one cache-line

---
 rtl/burst_line_master.sv | 176 +++++++++++++++++
 tb/tb_burst_line_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_master.sv
// Line-granular initiator for BurstRAM: one command per request, then streams write beats or gathers read beats.
// Optional feature macro: BURST_LINE_MASTER_WR_MASK_EN (per-byte write mask latched with the request).
module burst_line_master #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              req_valid,
  output logic                                              req_ready,
  input  logic                                              req_write,
  input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]     req_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]              req_wr_line,
`ifdef BURST_LINE_MASTER_WR_MASK_EN
  input  logic [DATA_BITWIDTH*BURST_COUNT/8-1:0]            req_wr_mask,
`endif
  output logic                                              resp_valid,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]              resp_rd_line,
  output logic                                              cmd,
  output logic                                              cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]                         addr,
  output logic [DATA_BITWIDTH-1:0]                          wr_data,
  output logic [DATA_BITWIDTH/8-1:0]                        data_mask,
  input  logic [DATA_BITWIDTH-1:0]                          rd_data,
  input  logic                                              rd_data_ready,
  input  logic                                              busy
);

  localparam int unsigned LINE_W = DATA_BITWIDTH * BURST_COUNT;
  localparam int unsigned MASK_W = DATA_BITWIDTH / 8;
  localparam int unsigned OFS_W  = $clog2(BURST_COUNT);
  localparam int unsigned CNT_W  = (OFS_W == 0) ? 1 : OFS_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_BURST, S_RESP} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt, w_next_idx;
  logic                      r_req_ready, w_req_ready_nxt;
  logic                      r_resp_valid, w_resp_valid_nxt;
  logic                      r_cmd, w_cmd_nxt;
  logic                      r_cmd_en, w_cmd_en_nxt;
  logic [DEPTH_BITWIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_BITWIDTH-1:0]  r_wr_data, w_wr_data_nxt;
  logic [MASK_W-1:0]         r_data_mask, w_data_mask_nxt;
  logic [LINE_W-1:0]         r_rd_buf, w_rd_buf_nxt;
  logic [LINE_W-1:0]         r_resp_rd_line, w_resp_rd_line_nxt;
  logic [LINE_W-1:0]         r_wr_line, w_wr_line_nxt;
`ifdef BURST_LINE_MASTER_WR_MASK_EN
  logic [LINE_W/8-1:0]       r_wr_mask, w_wr_mask_nxt;
`endif

  assign w_next_idx = r_cnt + CNT_W'(1);

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_req_ready_nxt    = 1'b0;
    w_resp_valid_nxt   = 1'b0;
    w_cmd_nxt          = r_cmd;
    w_cmd_en_nxt       = 1'b0;
    w_addr_nxt         = r_addr;
    w_wr_data_nxt      = r_wr_data;
    w_data_mask_nxt    = r_data_mask;
    w_rd_buf_nxt       = r_rd_buf;
    w_resp_rd_line_nxt = r_resp_rd_line;
    w_wr_line_nxt      = r_wr_line;
`ifdef BURST_LINE_MASTER_WR_MASK_EN
    w_wr_mask_nxt      = r_wr_mask;
`endif
    case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = !busy;
        if (req_valid && r_req_ready) begin
          w_req_ready_nxt = 1'b0;
          w_cmd_en_nxt    = 1'b1;
          w_cmd_nxt       = req_write;
          w_addr_nxt      = DEPTH_BITWIDTH'(req_addr) << OFS_W;
          w_cnt_nxt       = '0;
          if (req_write) begin
            w_wr_line_nxt = req_wr_line;
            w_wr_data_nxt = req_wr_line[DATA_BITWIDTH-1:0];
`ifdef BURST_LINE_MASTER_WR_MASK_EN
            w_wr_mask_nxt   = req_wr_mask;
            w_data_mask_nxt = req_wr_mask[MASK_W-1:0];
`endif
            w_state_nxt   = S_WR_BURST;
          end else begin
            w_state_nxt   = S_RD_WAIT;
          end
        end
      end
      // r_cnt is the index of the beat currently on wr_data.
      S_WR_BURST: begin
        if (r_cnt == LAST_BEAT) begin
          w_cnt_nxt        = '0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end else begin
          w_cnt_nxt     = w_next_idx;
          w_wr_data_nxt = r_wr_line[DATA_BITWIDTH*w_next_idx +: DATA_BITWIDTH];
`ifdef BURST_LINE_MASTER_WR_MASK_EN
          w_data_mask_nxt = r_wr_mask[MASK_W*w_next_idx +: MASK_W];
`endif
        end
      end
      // Gather into a private buffer so resp_rd_line only changes on completion.
      S_RD_WAIT: begin
        if (rd_data_ready) begin
          w_rd_buf_nxt[DATA_BITWIDTH*r_cnt +: DATA_BITWIDTH] = rd_data;
          if (r_cnt == LAST_BEAT) begin
            w_cnt_nxt          = '0;
            w_resp_rd_line_nxt = w_rd_buf_nxt;
            w_resp_valid_nxt   = 1'b1;
            w_state_nxt        = S_RESP;
          end else begin
            w_cnt_nxt = w_next_idx;
          end
        end
      end
      S_RESP: begin
        w_req_ready_nxt = !busy;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_req_ready    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_cmd          <= 1'b0;
      r_cmd_en       <= 1'b0;
      r_addr         <= '0;
      r_wr_data      <= '0;
      r_data_mask    <= '0;
      r_rd_buf       <= '0;
      r_resp_rd_line <= '0;
      r_wr_line      <= '0;
`ifdef BURST_LINE_MASTER_WR_MASK_EN
      r_wr_mask      <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_cmd          <= w_cmd_nxt;
      r_cmd_en       <= w_cmd_en_nxt;
      r_addr         <= w_addr_nxt;
      r_wr_data      <= w_wr_data_nxt;
      r_data_mask    <= w_data_mask_nxt;
      r_rd_buf       <= w_rd_buf_nxt;
      r_resp_rd_line <= w_resp_rd_line_nxt;
      r_wr_line      <= w_wr_line_nxt;
`ifdef BURST_LINE_MASTER_WR_MASK_EN
      r_wr_mask      <= w_wr_mask_nxt;
`endif
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rd_line = r_resp_rd_line;
  assign cmd          = r_cmd;
  assign cmd_en       = r_cmd_en;
  assign addr         = r_addr;
  assign wr_data      = r_wr_data;
  assign data_mask    = r_data_mask;

endmodule

// File: tb/tb_burst_line_master.sv
// Bench for burst_line_master: behavioural BurstRAM responder plus a word-array reference memory.
module tb_burst_line_master;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA   = 64;
  localparam int unsigned BURST  = 4;
  localparam int unsigned LINE_W = DATA * BURST;
  localparam int unsigned WORDS  = 16;
`ifdef BURST_LINE_MASTER_WR_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_addr;
  logic [LINE_W-1:0] req_wr_line;
  logic [31:0]       req_wr_mask;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_rd_line;
  logic              cmd;
  logic              cmd_en;
  logic [DEPTH-1:0]  addr;
  logic [DATA-1:0]   wr_data;
  logic [7:0]        data_mask;
  logic [DATA-1:0]   rd_data;
  logic              rd_data_ready;
  logic              busy;

  burst_line_master #(.DEPTH_BITWIDTH(DEPTH), .DATA_BITWIDTH(DATA), .BURST_COUNT(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wr_line(req_wr_line),
`ifdef BURST_LINE_MASTER_WR_MASK_EN
    .req_wr_mask(req_wr_mask),
`endif
    .resp_valid(resp_valid), .resp_rd_line(resp_rd_line), .cmd(cmd), .cmd_en(cmd_en),
    .addr(addr), .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_ready(rd_data_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    case (i)
      0: return 64'h3F5A2E14B7C6A980;
      1: return 64'h9D8E2F17AB4C3E6F;
      2: return 64'hA1C3F7E2D5B8A9C4;
      3: return 64'h7D4E9F2C1B6A3D8F;
      4: return 64'h6C4B9A8D2F5E3C7A;
      5: return 64'hE1A7D0B5C8F3E6A9;
      6: return 64'hF8E9D2C3B4A5F6E7;
      7: return 64'hD4E7F2C5B8A3D6E9;
      default: return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(3 * i)};
    endcase
  endfunction

  // BurstRAM stand-in: all observation and driving happens on the falling edge.
  logic [63:0] mem [WORDS];
  int          rd_left, rd_delay, wr_left, rd_beats_seen, cmd_en_cnt, resp_cnt;
  logic [3:0]  rd_ptr, wr_ptr;
  bit          stray_en, stray_pending;

  task automatic ram_write(input logic [3:0] a);
    for (int b = 0; b < 8; b++)
      if (!data_mask[b]) mem[a][8*b +: 8] = wr_data[8*b +: 8];
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    rd_data_ready = 1'b0; rd_data = '0;
    rd_left = 0; rd_delay = 0; wr_left = 0; rd_beats_seen = 0;
    cmd_en_cnt = 0; resp_cnt = 0; rd_ptr = '0; wr_ptr = '0; stray_pending = 1'b0;
    forever begin
      @(negedge clk);
      rd_data_ready = 1'b0;
      if (resp_valid) resp_cnt++;
      if (rst) begin
        rd_left = 0; wr_left = 0; stray_pending = 1'b0;
      end else begin
        if (wr_left > 0) begin
          ram_write(wr_ptr); wr_ptr++; wr_left--;
        end
        if (cmd_en) begin
          cmd_en_cnt++;
          if (cmd) begin
            ram_write(addr); wr_ptr = addr + 4'd1; wr_left = BURST - 1;
          end else begin
            rd_ptr = addr; rd_left = BURST; rd_delay = $urandom_range(3, 1); rd_beats_seen = 0;
          end
        end else if (rd_left > 0) begin
          if (rd_delay > 0) rd_delay--;
          else if ($urandom_range(3, 0) != 0) begin
            rd_data_ready = 1'b1; rd_data = mem[rd_ptr];
            rd_ptr++; rd_left--; rd_beats_seen++;
            if (rd_left == 0 && stray_en) stray_pending = 1'b1;
          end
        end else if (stray_pending) begin
          rd_data_ready = 1'b1; rd_data = {$urandom, $urandom}; stray_pending = 1'b0;
        end
      end
    end
  end

  logic [63:0] ref_mem [WORDS];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk); #1;
  endtask

  function automatic logic [LINE_W-1:0] ref_line(input int li);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BURST; k++) l[k*DATA +: DATA] = ref_mem[li*BURST + k];
    return l;
  endfunction

  // One full request: handshake, command cycle, write beats, response.
  task automatic do_xact(input logic wr, input logic [1:0] line, input logic [LINE_W-1:0] wline,
                         input logic [31:0] wmask);
    int c0, r0, guard, li;
    logic [31:0] em;
    c0 = cmd_en_cnt; r0 = resp_cnt; li = int'(line);
    em = MASK_EN ? wmask : 32'h0;
    req_write = wr; req_addr = line; req_wr_line = wline; req_wr_mask = wmask; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin nstep(); guard++; end
    chk("req_ready_timeout", LINE_W'(guard < 50), LINE_W'(1));
    nstep();
    req_valid = 1'b0;
    chk("cmd_en", LINE_W'(cmd_en), LINE_W'(1));
    chk("cmd", LINE_W'(cmd), LINE_W'(wr));
    chk("addr", LINE_W'(addr), LINE_W'({line, 2'b00}));
    chk("req_ready_low", LINE_W'(req_ready), LINE_W'(0));
    if (wr) begin
      for (int k = 0; k < BURST; k++) begin
        if (k > 0) begin
          nstep();
          chk("cmd_en_beat", LINE_W'(cmd_en), LINE_W'(0));
        end
        chk("wr_data", LINE_W'(wr_data), LINE_W'(wline[k*DATA +: DATA]));
        chk("data_mask", LINE_W'(data_mask), LINE_W'(em[k*8 +: 8]));
        for (int b = 0; b < 8; b++)
          if (!em[k*8 + b]) ref_mem[li*BURST + k][8*b +: 8] = wline[k*DATA + 8*b +: 8];
      end
    end
    guard = 0;
    while (!resp_valid && guard < 200) begin nstep(); guard++; end
    chk("resp_timeout", LINE_W'(guard < 200), LINE_W'(1));
    if (!wr) chk("resp_rd_line", resp_rd_line, ref_line(li));
    nstep();
    chk("resp_pulse", LINE_W'(resp_valid), LINE_W'(0));
    chk("cmd_en_count", LINE_W'(cmd_en_cnt - c0), LINE_W'(1));
    chk("resp_count", LINE_W'(resp_cnt - r0), LINE_W'(1));
  endtask

  initial begin
    int guard, r0;
    logic [LINE_W-1:0] wl;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    stray_en = 1'b0;
    rst = 1'b1; busy = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wr_line = '0; req_wr_mask = '0;
    repeat (3) nstep();
    chk("rst_req_ready", LINE_W'(req_ready), LINE_W'(0));
    chk("rst_resp_valid", LINE_W'(resp_valid), LINE_W'(0));
    chk("rst_cmd", LINE_W'(cmd), LINE_W'(0));
    chk("rst_cmd_en", LINE_W'(cmd_en), LINE_W'(0));
    chk("rst_addr", LINE_W'(addr), LINE_W'(0));
    chk("rst_wr_data", LINE_W'(wr_data), LINE_W'(0));
    chk("rst_data_mask", LINE_W'(data_mask), LINE_W'(0));
    chk("rst_resp_rd_line", resp_rd_line, '0);

    // Request held while BurstRAM initialises must not be accepted.
    rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd0;
    repeat (6) begin
      nstep();
      chk("busy_req_ready", LINE_W'(req_ready), LINE_W'(0));
    end
    chk("busy_no_cmd", LINE_W'(cmd_en_cnt), LINE_W'(0));
    busy = 1'b0;

    do_xact(1'b0, 2'd0, '0, '0);
    chk("line0_literal", resp_rd_line,
        {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4, 64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980});
    do_xact(1'b0, 2'd1, '0, '0);
    chk("line1_literal", resp_rd_line,
        {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7, 64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A});
    wl = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    do_xact(1'b1, 2'd2, wl, '0);
    do_xact(1'b0, 2'd2, '0, '0);
    chk("line2_readback", resp_rd_line, wl);

    // Reset in the middle of a read: burst abandoned, no response.
    req_write = 1'b0; req_addr = 2'd3; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin nstep(); guard++; end
    nstep();
    req_valid = 1'b0;
    guard = 0;
    while (rd_beats_seen < 2 && guard < 100) begin nstep(); guard++; end
    chk("midrd_beats_timeout", LINE_W'(guard < 100), LINE_W'(1));
    nstep();
    r0 = resp_cnt;
    rst = 1'b1;
    nstep();
    chk("midrd_req_ready", LINE_W'(req_ready), LINE_W'(0));
    chk("midrd_resp_valid", LINE_W'(resp_valid), LINE_W'(0));
    chk("midrd_cmd_en", LINE_W'(cmd_en), LINE_W'(0));
    rst = 1'b0;
    repeat (8) nstep();
    chk("midrd_no_resp", LINE_W'(resp_cnt - r0), LINE_W'(0));
    do_xact(1'b0, 2'd0, '0, '0);

`ifdef BURST_LINE_MASTER_WR_MASK_EN
    wl = '1;
    do_xact(1'b1, 2'd2, wl, 32'h0000_0001);
    do_xact(1'b0, 2'd2, '0, '0);
    chk("mask_readback", resp_rd_line,
        {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFF11});
`endif

    stray_en = 1'b1;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < LINE_W / 32; k++) wl[k*32 +: 32] = $urandom;
      do_xact(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), wl, $urandom);
      repeat ($urandom_range(2, 0)) nstep();
    end
    for (int li = 0; li < 4; li++) do_xact(1'b0, 2'(li), '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
